// File: rtl/hazard3_ahb_apb_bridge_pkg.sv
// hazard3_ahb_apb_pkg: AHB encodings and bridge FSM states shared by the AHB-to-APB bridge.
package hazard3_ahb_apb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;
    typedef enum logic [2:0] {
        IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2
    } bridge_state_t;
endpackage

// File: rtl/hazard3_ahb_apb_bridge.sv
// hazard3_ahb_apb_bridge: single-outstanding AHB5 subordinate driving an APB3 requester.
module hazard3_ahb_apb_bridge
    import hazard3_ahb_apb_pkg::*;
#(
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter int W_PADDR = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hsel,
    input  logic [W_ADDR-1:0]  haddr,
    input  logic               hwrite,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hsize,
    input  logic               hready,
    input  logic [W_DATA-1:0]  hwdata,
    output logic               hreadyout,
    output logic               hresp,
    output logic [W_DATA-1:0]  hrdata,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [W_PADDR-1:0] paddr,
    output logic [W_DATA-1:0]  pwdata,
    input  logic [W_DATA-1:0]  prdata,
    input  logic               pready,
    input  logic               pslverr
);
    bridge_state_t      r_state;
    logic               r_hreadyout, r_hresp, r_psel, r_penable, r_pwrite;
    logic [W_DATA-1:0]  r_hrdata, r_pwdata;
    logic [W_PADDR-1:0] r_paddr;
    logic               w_accept, w_bad_size;
    logic               w_unused;

    assign w_accept   = hsel && hready && htrans[1];
    assign w_bad_size = hsize > HSIZE_WORD;
    assign w_unused   = ^{haddr[W_ADDR-1:W_PADDR], htrans[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_paddr     <= haddr[W_PADDR-1:0];
                    r_pwrite    <= hwrite;
                    r_hreadyout <= 1'b0;
                    r_hresp     <= w_bad_size;
                    r_psel      <= !w_bad_size && !hwrite;
                    r_state     <= w_bad_size ? ERR1 : hwrite ? WDATA : SETUP;
                end
                WDATA: begin
                    r_pwdata <= hwdata;
                    r_psel   <= 1'b1;
                    r_state  <= SETUP;
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: if (pready) begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    if (pslverr) begin
                        r_hresp <= 1'b1;
                        r_state <= ERR1;
                    end else begin
                        r_hreadyout <= 1'b1;
                        if (!r_pwrite) r_hrdata <= prdata;
                        r_state <= IDLE;
                    end
                end
                ERR1: begin
                    r_hreadyout <= 1'b1;
                    r_state     <= ERR2;
                end
                ERR2: begin
                    r_hresp <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;
    assign hrdata    = r_hrdata;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
endmodule

// File: tb/tb_hazard3_ahb_apb_bridge.sv
// tb_hazard3_ahb_apb_bridge: directed checks of the AHB-to-APB bridge with hand-computed expectations.
module tb_hazard3_ahb_apb_bridge;
    logic        clk = 1'b0, rst = 1'b1;
    logic        hsel = 1'b0, hwrite = 1'b0, hready = 1'b1;
    logic [31:0] haddr = '0, hwdata = '0, prdata = '0;
    logic [1:0]  htrans = 2'd0;
    logic [2:0]  hsize = 3'd2;
    logic        pready = 1'b1, pslverr = 1'b0;
    logic        hreadyout, hresp, psel, penable, pwrite;
    logic [31:0] hrdata, pwdata;
    logic [15:0] paddr;
    int n_vec = 0, n_err = 0;

    hazard3_ahb_apb_bridge dut (
        .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .hready(hready), .hwdata(hwdata),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .psel(psel),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel = 1'b1; htrans = 2'd2; haddr = a; hwrite = w; hsize = sz;
    endtask

    task automatic no_addr();
        hsel = 1'b0; htrans = 2'd0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_psel_penable", {30'd0, psel, penable}, 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        rst = 1'b0;
        tick();
        // Idle traffic: BUSY selected, then unselected NONSEQ
        hsel = 1'b1; htrans = 2'd1; tick();
        chk("busy_ready", {30'd0, hreadyout, psel}, 32'b10);
        hsel = 1'b0; htrans = 2'd2; tick();
        chk("unsel_ready", {30'd0, hreadyout, psel}, 32'b10);
        // Read 0x1004
        prdata = 32'hDEADBEEF;
        addr_phase(32'h0000_1004, 1'b0, 3'd2); tick(); no_addr();
        chk("rd_setup_psel_pen", {30'd0, psel, penable}, 32'b10);
        chk("rd_setup_paddr", 32'(paddr), 32'h1004);
        chk("rd_setup_pwrite", 32'(pwrite), 32'd0);
        chk("rd_setup_hready", 32'(hreadyout), 32'd0);
        tick();
        chk("rd_access_psel_pen", {30'd0, psel, penable}, 32'b11);
        chk("rd_access_hready", 32'(hreadyout), 32'd0);
        tick();
        chk("rd_done_hready_hresp", {30'd0, hreadyout, hresp}, 32'b10);
        chk("rd_done_hrdata", hrdata, 32'hDEADBEEF);
        chk("rd_done_psel", {30'd0, psel, penable}, 32'b00);
        // Write 0x0008; hwdata is scrambled after capture to prove pwdata holds
        addr_phase(32'h0000_0008, 1'b1, 3'd2); tick(); no_addr();
        hwdata = 32'h12345678;
        chk("wr_wdata_state", {29'd0, hreadyout, psel, penable}, 32'b000);
        tick(); hwdata = 32'h0;
        chk("wr_setup", {29'd0, psel, penable, pwrite}, 32'b101);
        chk("wr_setup_pwdata", pwdata, 32'h12345678);
        chk("wr_setup_paddr", 32'(paddr), 32'h0008);
        tick();
        chk("wr_access", {29'd0, psel, penable, pwrite}, 32'b111);
        chk("wr_access_pwdata", pwdata, 32'h12345678);
        chk("wr_access_hready", 32'(hreadyout), 32'd0);
        tick();
        chk("wr_done_hready_hresp", {30'd0, hreadyout, hresp}, 32'b10);
        chk("wr_keeps_hrdata", hrdata, 32'hDEADBEEF);
        chk("wr_done_pwdata_hold", pwdata, 32'h12345678);
        // Read with three pready wait cycles, completes at cycle 6
        pready = 1'b0; prdata = 32'hCAFEF00D;
        addr_phase(32'h0000_0040, 1'b0, 3'd0); tick(); no_addr();
        tick();
        for (int i = 3; i <= 5; i++) begin
            tick();
            chk($sformatf("wait_c%0d_apb", i), {29'd0, psel, penable, hreadyout}, 32'b110);
            chk($sformatf("wait_c%0d_paddr", i), 32'(paddr), 32'h0040);
        end
        pready = 1'b1; tick();
        chk("wait_done_hready", 32'(hreadyout), 32'd1);
        chk("wait_done_hrdata", hrdata, 32'hCAFEF00D);
        // Write with pslverr
        hwdata = 32'hA5A5A5A5;
        addr_phase(32'h0000_0010, 1'b1, 3'd2); tick(); no_addr();
        tick(); pslverr = 1'b1;
        tick();
        chk("err_access", {30'd0, psel, penable}, 32'b11);
        tick(); pslverr = 1'b0;
        chk("err1_resp", {29'd0, hresp, hreadyout, psel}, 32'b100);
        tick();
        chk("err2_resp", {29'd0, hresp, hreadyout, psel}, 32'b110);
        addr_phase(32'h0000_0050, 1'b0, 3'd2); tick(); no_addr();
        chk("err_idle_resp", {29'd0, hresp, hreadyout, psel}, 32'b010);
        tick();
        chk("err2_addr_ignored", {29'd0, hresp, hreadyout, psel}, 32'b010);
        // Back-to-back: read, then write presented in the read's completion cycle
        prdata = 32'h11111111;
        addr_phase(32'h0000_0020, 1'b0, 3'd2); tick(); no_addr();
        chk("b2b_rd_paddr", 32'(paddr), 32'h0020);
        tick(); tick();
        chk("b2b_rd_done", {30'd0, hreadyout, psel}, 32'b10);
        chk("b2b_rd_hrdata", hrdata, 32'h11111111);
        addr_phase(32'h0000_0024, 1'b1, 3'd2); tick(); no_addr();
        hwdata = 32'h22222222;
        chk("b2b_gap_psel", {30'd0, hreadyout, psel}, 32'b00);
        tick();
        chk("b2b_wr_setup", {29'd0, psel, penable, pwrite}, 32'b101);
        chk("b2b_wr_paddr", 32'(paddr), 32'h0024);
        chk("b2b_wr_pwdata", pwdata, 32'h22222222);
        tick(); tick();
        chk("b2b_wr_done", {29'd0, hreadyout, hresp, psel}, 32'b100);
        // Oversized read: error response without APB activity
        addr_phase(32'h0000_0030, 1'b0, 3'd3); tick(); no_addr();
        chk("sz3_err1", {29'd0, hresp, hreadyout, psel}, 32'b100);
        tick();
        chk("sz3_err2", {29'd0, hresp, hreadyout, psel}, 32'b110);
        tick();
        chk("sz3_idle", {29'd0, hresp, hreadyout, psel}, 32'b010);
        // Asynchronous reset during ACCESS
        pready = 1'b0;
        addr_phase(32'h0000_0060, 1'b0, 3'd2); tick(); no_addr();
        tick();
        chk("rst_mid_access", {29'd0, psel, penable, hreadyout}, 32'b110);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_drop", {29'd0, psel, penable, hreadyout}, 32'b001);
        chk("rst_async_paddr", 32'(paddr), 32'd0);
        pready = 1'b1;
        tick(); rst = 1'b0; tick();
        chk("rst_after_idle", {29'd0, hresp, hreadyout, psel}, 32'b010);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
